fc_layer_stream: RTL and testbench
==================================

Name: fc_layer_stream

Overview:
Parametrised fully-connected layer. It loads an input vector, a neuron-major weight matrix and a bias vector over one ready/valid stream, then computes OUT_SIZE dot products with one MAC per cycle. Each neuron result is rounded, saturated and optionally ReLU'd, then emitted over a ready/valid output with backpressure. A running argmax gives the predicted class when the layer finishes. It is the classifier stage after the conv/pool feature path.

Parameters:
IN_SIZE, 75, input vector length (>=2)
OUT_SIZE, 10, neuron count (>=2)
DATA_WIDTH, 16, signed width of activations, weights, biases and outputs
FRAC_BITS, 13, fractional bits of the shared Qm.n format (1 <= FRAC_BITS < DATA_WIDTH)
ACC_WIDTH, 40, signed accumulator width (>= 2*DATA_WIDTH + clog2(IN_SIZE) + 1)
RELU_EN, 0, 1 = clamp negative outputs to 0

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start_fc  in  1  single-cycle start pulse; honoured only in IDLE
load_valid  in  1  load word valid
load_ready  out  1  high throughout LOAD
load_data  in  DATA_WIDTH  signed load word
out_valid  out  1  neuron result valid
out_ready  in  1  consumer accepts result
out_data  out  DATA_WIDTH  signed neuron result
out_idx  out  clog2(OUT_SIZE)  neuron index of out_data
finish_fc  out  1  one-cycle pulse after last neuron accepted
class_out  out  clog2(OUT_SIZE)  argmax neuron index, held until next start_fc
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: async on reset_n low. State IDLE; all outputs 0; counters, accumulator, argmax registers cleared; memory contents don't-care. Reset mid-operation aborts the layer with no finish_fc.
- States: IDLE -> LOAD (start_fc) -> COMPUTE -> EMIT -> (COMPUTE for next neuron | DONE) -> IDLE.
- LOAD: load_ready=1. A word transfers when load_valid && load_ready. Words arrive in this order: IN_SIZE activations x[0..], then IN_SIZE*OUT_SIZE weights w[o*IN_SIZE+i] with o outer, then OUT_SIZE biases. Gaps in load_valid stall without loss. On the cycle after the final word transfers, go to COMPUTE with o=0, i=0. start_fc outside IDLE is ignored.
- COMPUTE, one MAC per cycle:
  - i==0: acc <= (sign_ext(b[o]) <<< FRAC_BITS) + x[0]*w[o*IN_SIZE]. The bias is aligned to the product scale.
  - i>0: acc <= acc + x[i]*w[o*IN_SIZE+i].
  - After i==IN_SIZE-1, go to EMIT.
  - Each neuron takes exactly IN_SIZE cycles. out_valid first rises IN_SIZE+1 cycles after the final load transfer.
- EMIT:
  - r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half up, arithmetic shift).
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If RELU_EN, negative results become 0.
  - out_valid=1 with out_data/out_idx stable until out_ready. On the handshake, out_valid drops next cycle.
  - If o<OUT_SIZE-1: o++ and return to COMPUTE. Otherwise go to DONE.
  - No result is ever dropped or duplicated, whatever out_ready does.
- Argmax: updated on each EMIT handshake using the post-saturation/ReLU value.
  - o==0 loads unconditionally.
  - Later neurons replace the best only if strictly greater, so ties keep the lowest index.
- DONE: one cycle. finish_fc=1 and class_out is written with the final argmax. Then go to IDLE. class_out holds until the next start_fc clears it to 0.
- Arithmetic: all products are signed DATA_WIDTH x DATA_WIDTH giving 2*DATA_WIDTH, sign-extended to ACC_WIDTH. The accumulator must not overflow under the ACC_WIDTH constraint.

Test Plan:
1. IN_SIZE=3, OUT_SIZE=2. x=8192 (1.0), all w=4096 (0.5), b={0,8192} -> out_data {12288, 20480}, out_idx {0,1}, class_out=1, finish_fc pulse one cycle after second handshake.
2. Saturation, out_ready tied high: x=32767, w=32767 -> out_data 32767. x=32767, w=-32768 -> -32768. With RELU_EN=1 the negative case gives 0.
3. Rounding: x={1,0,0}, w row={4096,0,0}, b=0 -> 1. Same with x={-1,0,0} -> 0.
4. Backpressure: hold out_ready low 5 cycles during EMIT -> out_valid stays high, out_data/out_idx stable, no MAC advance. Release -> next neuron emitted exactly IN_SIZE+1 cycles later.
5. Load stalls: toggle load_valid every other cycle; pulse start_fc during LOAD -> identical results to test 1, extra start ignored. Tie case with equal outputs -> class_out=0.
6. Assert reset_n mid-COMPUTE -> all outputs 0, busy=0, load_ready=0 immediately. A fresh start_fc then completes test 1 correctly.

Source files
------------

// File: rtl/fc_layer_stream.sv
// ---------------------------------------------------------------------------
// fc_layer_stream
//   Streaming fully-connected layer. An input vector, a neuron-major weight
//   matrix and a bias vector are loaded over one ready/valid stream into a
//   local word store. The layer then runs one MAC per cycle per neuron. Each
//   neuron result is rounded, saturated and optionally ReLU'd, then offered on
//   a ready/valid output. A running argmax of the emitted values gives the
//   predicted class when the layer finishes.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start_fc   start pulse, honoured only while idle
//   load_valid / load_ready / load_data   load stream, in this order:
//              x[0..IN-1], w[o*IN+i] (o outer), b[0..OUT-1]
//   out_valid / out_ready / out_data / out_idx   per-neuron result stream
//   finish_fc  one-cycle pulse after the last neuron is accepted
//   class_out  argmax neuron index, held until the next start_fc
//   busy       high whenever the layer is not idle
// ---------------------------------------------------------------------------
module fc_layer_stream #(
  parameter int IN_SIZE    = 75,
  parameter int OUT_SIZE   = 10,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 13,
  parameter int ACC_WIDTH  = 40,
  parameter int RELU_EN    = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start_fc,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic signed [DATA_WIDTH-1:0]  load_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_WIDTH-1:0]  out_data,
  output logic [$clog2(OUT_SIZE)-1:0]   out_idx,
  output logic                          finish_fc,
  output logic [$clog2(OUT_SIZE)-1:0]   class_out,
  output logic                          busy
);

  localparam int LD_TOTAL = IN_SIZE * (OUT_SIZE + 1) + OUT_SIZE;
  localparam int LD_W     = $clog2(LD_TOTAL);
  localparam int I_W      = $clog2(IN_SIZE);
  localparam int O_W      = $clog2(OUT_SIZE);

  localparam logic [LD_W-1:0] LD_LAST = LD_W'(LD_TOTAL - 1);
  localparam logic [LD_W-1:0] W_BASE  = LD_W'(IN_SIZE);
  localparam logic [LD_W-1:0] B_BASE  = LD_W'(IN_SIZE * (OUT_SIZE + 1));
  localparam logic [I_W-1:0]  I_LAST  = I_W'(IN_SIZE - 1);
  localparam logic [O_W-1:0]  O_LAST  = O_W'(OUT_SIZE - 1);

  localparam logic signed [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0]  ROUND_K = ACC_WIDTH'(1) << (FRAC_BITS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_EMIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]                   state;
  logic [LD_W-1:0]              ld_cnt;
  logic [LD_W-1:0]              w_ptr;     // walks the weight block linearly across neurons
  logic [I_W-1:0]               i;
  logic [O_W-1:0]               o;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH-1:0] best_val;
  logic [O_W-1:0]               best_idx;

  // Single flat store: activations, then weights, then biases.
  logic signed [DATA_WIDTH-1:0] mem [LD_TOTAL];

  logic signed [DATA_WIDTH-1:0]   x_val, w_val, b_val, sat;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    bias_ext, prod_ext, rounded;
  logic                           better;
  logic [O_W-1:0]                 next_best_idx;

  assign load_ready = (state == S_LOAD);
  assign busy       = (state != S_IDLE);
  assign finish_fc  = (state == S_DONE);

  assign x_val    = mem[LD_W'(i)];
  assign w_val    = mem[w_ptr];
  assign b_val    = mem[B_BASE + LD_W'(o)];
  assign prod     = x_val * w_val;
  assign prod_ext = ACC_WIDTH'(prod);
  // Bias is moved onto the product scale (2*FRAC_BITS fractional bits).
  assign bias_ext = ACC_WIDTH'(b_val) <<< FRAC_BITS;
  assign rounded  = (acc + ROUND_K) >>> FRAC_BITS;

  always_comb begin
    // NOTE: sat gets a value on every path before the ReLU override, so the
    // block stays purely combinational and no latch is inferred.
    if (rounded > ACC_WIDTH'(D_MAX))      sat = D_MAX;
    else if (rounded < ACC_WIDTH'(D_MIN)) sat = D_MIN;
    else                                  sat = rounded[DATA_WIDTH-1:0];
    if (RELU_EN != 0 && sat[DATA_WIDTH-1]) sat = '0;
  end

  // Neuron 0 seeds the argmax; later neurons win only when strictly greater.
  assign better        = (out_idx == '0) || (out_data > best_val);
  assign next_best_idx = better ? out_idx : best_idx;

  // NOTE: the store is not reset; every word is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && load_valid) mem[ld_cnt] <= load_data;
  end

  // NOTE: all state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ld_cnt    <= '0;
      w_ptr     <= '0;
      i         <= '0;
      o         <= '0;
      acc       <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      class_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_fc) begin
            state     <= S_LOAD;
            ld_cnt    <= '0;
            class_out <= '0;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            if (ld_cnt == LD_LAST) begin
              state <= S_COMPUTE;
              i     <= '0;
              o     <= '0;
              w_ptr <= W_BASE;
            end else begin
              ld_cnt <= ld_cnt + LD_W'(1);
            end
          end
        end
        S_COMPUTE: begin
          acc   <= (i == '0) ? (bias_ext + prod_ext) : (acc + prod_ext);
          w_ptr <= w_ptr + LD_W'(1);
          if (i == I_LAST) begin
            i     <= '0;
            state <= S_EMIT;
          end else begin
            i <= i + I_W'(1);
          end
        end
        S_EMIT: begin
          // First EMIT cycle registers the result; later cycles wait for out_ready.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= sat;
            out_idx   <= o;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            best_idx  <= next_best_idx;
            if (better) best_val <= out_data;
            if (o == O_LAST) begin
              state     <= S_DONE;
              class_out <= next_best_idx;
            end else begin
              o     <= o + O_W'(1);
              state <= S_COMPUTE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_stream.sv
// ---------------------------------------------------------------------------
// tb_fc_layer_stream
//   Two instances (RELU_EN=0 and RELU_EN=1) share all stimulus. Expected
//   neuron results and classes are hand-computed and queued per instance; a
//   monitor pops and compares on every output handshake and finish pulse.
// ---------------------------------------------------------------------------
module tb_fc_layer_stream;

  localparam int IN  = 3;
  localparam int OUT = 2;
  localparam int NW  = IN * (OUT + 1) + OUT;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start_fc, load_valid, out_ready;
  logic signed [15:0] load_data;
  logic [1:0]         load_ready, out_valid, finish_fc, busy;
  logic signed [15:0] out_data [2];
  logic [0:0]         out_idx [2];
  logic [0:0]         class_out [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fc_layer_stream #(
      .IN_SIZE(IN), .OUT_SIZE(OUT), .DATA_WIDTH(16), .FRAC_BITS(13),
      .ACC_WIDTH(40), .RELU_EN(g)
    ) dut (
      .clk(clk), .reset_n(reset_n), .start_fc(start_fc),
      .load_valid(load_valid), .load_ready(load_ready[g]), .load_data(load_data),
      .out_valid(out_valid[g]), .out_ready(out_ready), .out_data(out_data[g]),
      .out_idx(out_idx[g]), .finish_fc(finish_fc[g]), .class_out(class_out[g]),
      .busy(busy[g])
    );
  end

  typedef struct { int data; int idx; } exp_t;
  exp_t q0[$], q1[$];
  int   cq0[$], cq1[$];
  int   n_cmp = 0, n_bad = 0;
  int   vec [NW];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int amax(input int a, input int b);
    return (b > a) ? 1 : 0;
  endfunction

  task automatic set_vec(input int x0, x1, x2, w0, w1, w2, w3, w4, w5, b0, b1);
    vec = '{x0, x1, x2, w0, w1, w2, w3, w4, w5, b0, b1};
  endtask

  // Queue hand-computed raw results for both instances.
  task automatic expect_run(input int e0, input int e1);
    q0.push_back('{e0, 0});       q0.push_back('{e1, 1});
    q1.push_back('{relu(e0), 0}); q1.push_back('{relu(e1), 1});
    cq0.push_back(amax(e0, e1));
    cq1.push_back(amax(relu(e0), relu(e1)));
  endtask

  // Monitor: compares every handshake, every finish pulse and its timing.
  initial begin
    bit   fin_due [2];
    bit   have;
    exp_t e;
    int   c;
    fin_due = '{0, 0};
    forever begin
      @(negedge clk);
      if (reset_n) begin
        for (int g = 0; g < 2; g++) begin
          if (fin_due[g]) begin
            check("finish_after_last", finish_fc[g], 1);
            fin_due[g] = 1'b0;
          end
          if (finish_fc[g]) begin
            have = (g == 0) ? (cq0.size() != 0) : (cq1.size() != 0);
            if (!have) check("unexpected_finish", finish_fc[g], 0);
            else begin
              if (g == 0) c = cq0.pop_front(); else c = cq1.pop_front();
              check("class_out", class_out[g], c);
            end
          end
          if (out_valid[g] && out_ready) begin
            have = (g == 0) ? (q0.size() != 0) : (q1.size() != 0);
            if (!have) check("unexpected_out", out_data[g], 0);
            else begin
              if (g == 0) e = q0.pop_front(); else e = q1.pop_front();
              check("out_data", out_data[g], e.data);
              check("out_idx", out_idx[g], e.idx);
              if (e.idx == OUT - 1) fin_due[g] = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic do_load(input bit stall, input bit extra_start);
    int k, cyc;
    bit v, rdy;
    start_fc = 1'b1;
    @(posedge clk); #1;
    start_fc = 1'b0;
    check("class_cleared", class_out[0], 0);
    check("busy_in_load", busy[0], 1);
    k = 0;
    cyc = 0;
    while (k < NW && cyc < 100) begin
      v          = stall ? cyc[0] : 1'b1;
      load_valid = v;
      load_data  = 16'(vec[k]);
      start_fc   = extra_start && (cyc == 2);
      rdy        = load_ready[0];
      @(posedge clk); #1;
      if (v && rdy) k++;
      cyc++;
    end
    load_valid = 1'b0;
    start_fc   = 1'b0;
    check("load_done", k, NW);
  endtask

  task automatic run(input bit stall, input bit extra_start, input bit hold);
    int n;
    do_load(stall, extra_start);
    n = 0;
    while (!out_valid[0] && n < 50) begin @(posedge clk); #1; n++; end
    check("first_valid_latency", n, IN + 1);
    if (hold) begin
      repeat (5) begin
        @(posedge clk); #1;
        check("hold_valid", out_valid[0], 1);
        check("hold_data", out_data[0], 12288);
        check("hold_idx", out_idx[0], 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (!out_valid[0] && n < 50) begin @(posedge clk); #1; n++; end
      check("next_neuron_latency", n, IN + 1);
    end
    n = 0;
    while (!finish_fc[0] && n < 100) begin @(posedge clk); #1; n++; end
    check("finish_seen", finish_fc[0], 1);
    @(posedge clk); #1;
    check("finish_one_cycle", finish_fc[0], 0);
    check("busy_after_done", busy[0], 0);
    check("queue_drained", q0.size() + q1.size() + cq0.size() + cq1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    start_fc   = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    out_ready  = 1'b1;
    #22;
    for (int g = 0; g < 2; g++) begin
      check("rst_out_valid", out_valid[g], 0);
      check("rst_busy", busy[g], 0);
      check("rst_load_ready", load_ready[g], 0);
      check("rst_class", class_out[g], 0);
    end
    @(posedge clk); #1 reset_n = 1'b1;

    // Basic layer: 1.0 * 0.5 * 3 = 1.5, second neuron adds bias 1.0.
    set_vec(8192, 8192, 8192, 4096, 4096, 4096, 4096, 4096, 4096, 0, 8192);
    expect_run(12288, 20480);
    run(0, 0, 0);

    // Positive and negative saturation.
    set_vec(32767, 32767, 32767, 32767, 32767, 32767, -32768, -32768, -32768, 0, 0);
    expect_run(32767, -32768);
    run(0, 0, 0);

    // Rounding: +0.5 LSB rounds up to 1, -0.5 LSB rounds up to 0.
    set_vec(1, 0, 0, 4096, 0, 0, -4096, 0, 0, 0, 0);
    expect_run(1, 0);
    run(0, 0, 0);

    // Just below -0.5 LSB rounds to -1; exactly -0.5 LSB to 0.
    set_vec(-1, 0, 0, 4096, 0, 0, 4097, 0, 0, 0, 0);
    expect_run(0, -1);
    run(0, 0, 0);

    // Backpressure on the first neuron.
    set_vec(8192, 8192, 8192, 4096, 4096, 4096, 4096, 4096, 4096, 0, 8192);
    expect_run(12288, 20480);
    out_ready = 1'b0;
    run(0, 0, 1);

    // Load gaps plus a stray start during LOAD.
    expect_run(12288, 20480);
    run(1, 1, 0);

    // Tie keeps the lowest index.
    set_vec(8192, 0, 0, 4096, 0, 0, 4096, 0, 0, 0, 0);
    expect_run(4096, 4096);
    run(0, 0, 0);

    // Reset mid-COMPUTE aborts, then a clean rerun.
    set_vec(8192, 8192, 8192, 4096, 4096, 4096, 4096, 4096, 4096, 0, 8192);
    do_load(0, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check("abort_out_valid", out_valid[g], 0);
      check("abort_busy", busy[g], 0);
      check("abort_load_ready", load_ready[g], 0);
      check("abort_finish", finish_fc[g], 0);
      check("abort_out_data", out_data[g], 0);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    expect_run(12288, 20480);
    run(0, 0, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
